// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fix-up applied as the last iteration retires.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic             a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res;

  assign a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign b_signed = a_signed && (op != 3'b010);
  assign a_neg    = a_signed & a[WIDTH-1];
  assign b_neg    = b_signed & b[WIDTH-1];
  assign a_mag    = a_neg ? (~a + 1'b1) : a;
  assign b_mag    = b_neg ? (~b + 1'b1) : b;
  assign div_zero = op[2] && (b == '0);
  assign div_ovf  = op[2] && !op[0] && (a == MIN_VAL) && (b == '1);
  assign spec_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] iter_acc, prod_fix;
  logic [WIDTH-1:0]   div_sel, div_fix, fin_res;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};

  always_comb begin
    iter_acc = {mul_sum, acc_q[WIDTH-1:1]};
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) iter_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  iter_acc = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign prod_fix = neg_q ? (~iter_acc + 1'b1) : iter_acc;
  assign div_sel  = op_q[1] ? iter_acc[2*WIDTH-1:WIDTH] : iter_acc[WIDTH-1:0];
  assign div_fix  = neg_q ? (~div_sel + 1'b1) : div_sel;
  assign fin_res  = op_q[2] ? div_fix :
                    (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    b_d     = b_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !kill) begin
          op_d  = op;
          // Remainder follows the dividend; everything else follows the sign product.
          neg_d = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d = {{WIDTH{1'b0}}, a_mag};
          b_d   = b_mag;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            out_d   = spec_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = iter_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            out_d   = fin_res;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (kill || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed ISA vectors, handshake/kill/reset scenarios and
// randomized operations checked against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic        clk, rst, in_valid, in_ready, kill, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b, out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, ux, uy, p;
    longint unsigned up;
    logic [31:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    r  = '0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin up = longint'(ux) * longint'(uy); r = up[63:32]; end
      3'd4: begin
        if (y == 0) r = ALL1;
        else if (x == MINV && y == ALL1) r = x;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: begin
        if (y == 0) r = ALL1;
        else begin p = ux / uy; r = p[31:0]; end
      end
      3'd6: begin
        if (y == 0) r = x;
        else if (x == MINV && y == ALL1) r = '0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: begin
        if (y == 0) r = x;
        else begin p = ux % uy; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || (!o[0] && x == MINV && y == ALL1));
  endfunction

  // Drives one request, scrambles inputs after accept, waits for the result and retires it.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("txn op=%0d a=%h b=%h out=%h lat=%0d", o, x, y, res, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h, required 1 0 00000000", in_ready, out_valid, out);
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mul_latency();
    int lat;
    bit ready_low;
    op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    $display("txn op=0 a=00000007 b=fffffffd out=%h lat=%0d", out, lat);
    n_checks++;
    if (out !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_value: got %h, required ffffffeb", out); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d, required 33", lat); end
    n_checks++;
    if (ready_low !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_calc: in_ready rose during CALC"); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  vo [11] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] va [11] = '{MINV, ALL1, ALL1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, ALL1, ALL1,
                             32'd5, 32'd5, MINV, MINV};
    logic [31:0] vb [11] = '{MINV, ALL1, 32'd2, 32'd2, 32'd2, 32'h10, 32'h10, 32'd0, 32'd0, ALL1, ALL1};
    logic [31:0] ve [11] = '{32'h4000_0000, 32'hFFFF_FFFE, ALL1, 32'hFFFF_FFFD, ALL1, 32'h0FFF_FFFF,
                             32'hF, ALL1, 32'd5, MINV, 32'd0};
    int          vl [11] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      do_op(vo[i], va[i], vb[i], res, lat);
      n_checks++;
      if (res !== ve[i] || lat !== vl[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: out=%h lat=%0d, required %h lat=%0d", i, res, lat, ve[i], vl[i]);
      end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    int   lat;
    bit   stable;
    op = 3'd5; a = ALL1; b = 32'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 3'd0; a = 32'd3; b = 32'd5;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out !== 32'h0FFF_FFFF || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!stable || out !== 32'h0FFF_FFFF || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_hold: out=%h out_valid=%b, required 0fffffff held 5 cycles", out, out_valid);
    end
    $display("txn op=5 a=ffffffff b=00000010 out=%h held", out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    $display("txn op=0 a=00000003 b=00000005 out=%h lat=%0d", out, lat);
    n_checks++;
    if (out !== 32'd15 || lat !== 33) begin
      n_fail++;
      $display("FAIL b2b_second: out=%h lat=%0d, required 0000000f lat=33", out, lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_kill();
    bit          saw;
    logic [31:0] res;
    int          lat;
    op = 3'd4; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_calc: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    saw = 1'b0;
    repeat (40) begin if (out_valid) saw = 1'b1; @(posedge clk); #1; end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL kill_no_pulse: out_valid seen=1, required 0"); end
    op = 3'd7; a = 32'd5; b = 32'd0; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    op = 3'd5; a = 32'd9; b = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_done: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    do_op(3'd6, 32'd17, 32'd5, res, lat);
    n_checks++;
    if (res !== 32'd2 || lat !== 33) begin
      n_fail++;
      $display("FAIL kill_recover: out=%h lat=%0d, required 00000002 lat=33", res, lat);
    end
  endtask

  task automatic test_async_reset();
    bit saw;
    op = 3'd3; a = ALL1; b = ALL1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b out=%h, required 1 0 00000000", in_ready, out_valid, out);
    end
    #2 rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL async_reset_no_result: partial result escaped"); end
  endtask

  task automatic test_random(input int n);
    logic [2:0]  o;
    logic [31:0] x, y, res, e, other, lhs;
    int          lat, el;
    for (int i = 0; i < n; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: begin x = $urandom; y = 32'd0; end
        1: begin x = MINV; y = ALL1; end
        2: begin x = 32'($urandom_range(0, 40)) - 32'd20; y = 32'($urandom_range(0, 16)) - 32'd8; end
        default: begin x = $urandom; y = $urandom >> $urandom_range(0, 31); end
      endcase
      e  = ref_model(o, x, y);
      el = is_fast(o, x, y) ? 1 : 33;
      do_op(o, x, y, res, lat);
      n_checks++;
      if (res !== e || lat !== el) begin
        n_fail++;
        $display("FAIL random_%0d: op=%0d a=%h b=%h out=%h lat=%0d, required %h lat=%0d", i, o, x, y, res, lat, e, el);
      end
      if (o[2]) begin
        if (o[1]) begin other = ref_model({2'b10, o[0]}, x, y); lhs = other * y + res; end
        else      begin other = ref_model({2'b11, o[0]}, x, y); lhs = res * y + other; end
        n_checks++;
        if (lhs !== x) begin
          n_fail++;
          $display("FAIL invariant_%0d: q*b+r=%h, required a=%h", i, lhs, x);
        end
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          acc_n, done_n, cyc;
    acc_n = 0; done_n = 0; cyc = 0;
    while (done_n < n && cyc < 8000) begin
      if (acc_n < n) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin exp_q.push_back(ref_model(op, a, b)); acc_n++; end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious: out=%h with no request outstanding", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin n_fail++; $display("FAIL b2b_txn_%0d: out=%h, required %h", done_n, out, e); end
          $display("txn b2b %0d out=%h", done_n, out);
        end
        done_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (done_n !== n) begin n_fail++; $display("FAIL b2b_count: completed %0d, required %0d", done_n, n); end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_directed();
    test_back_to_back_backpressure();
    test_kill();
    test_async_reset();
    test_random(1200);
    test_back_to_back(150);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
